// File: rtl/demux_1x4_reg.sv
// rtl/demux_1x4_reg.sv - registered 1-to-4 demux (3 channels + null drop) with one-entry pending buffer
module demux_1x4_reg #(
    parameter int BITS     = 12,                // data width of input and every channel
    parameter int CNT_BITS = 8                  // width of the saturating drop counter
) (
    input  logic                clk,            // rising-edge clock
    input  logic                rst,            // synchronous reset, active-high
    input  logic [BITS-1:0]     in_data,        // input word
    input  logic [1:0]          in_sel,         // 00/01/10 -> ch0/1/2, 11 -> drop
    input  logic                in_valid,       // input word valid
    output logic                in_ready,       // block can accept a word
    output logic [BITS-1:0]     out0_data,      // channel 0 word
    output logic [BITS-1:0]     out1_data,      // channel 1 word
    output logic [BITS-1:0]     out2_data,      // channel 2 word
    output logic [2:0]          out_valid,      // per-channel valid
    input  logic [2:0]          out_ready,      // per-channel ready
    output logic [CNT_BITS-1:0] drop_cnt        // saturating count of dropped words
);

    typedef enum logic {IDLE, STALL} state_t;

    state_t          state, state_nxt;
    logic [BITS-1:0] pend_data, pend_data_nxt;
    logic [1:0]      pend_sel, pend_sel_nxt;

    logic            accept;
    logic [2:0]      xfer;
    logic [2:0]      slot_free;
    logic [3:0]      in_oh;     // one-hot of in_sel, bit 3 is the null code
    logic [3:0]      pend_oh;   // one-hot of pend_sel
    logic [2:0]      wr;        // slot write enables for this edge
    logic [BITS-1:0] wr_data;
    logic            drop;

    assign in_ready  = (state == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid & out_ready;
    // A slot draining this cycle can take a new word at the same edge.
    assign slot_free = ~out_valid | out_ready;
    assign in_oh     = 4'b0001 << in_sel;
    assign pend_oh   = 4'b0001 << pend_sel;

    always_comb begin
        state_nxt     = state;
        pend_data_nxt = pend_data;
        pend_sel_nxt  = pend_sel;
        wr            = 3'b000;
        wr_data       = in_data;
        drop          = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (in_oh[3]) begin
                        drop = 1'b1;
                    end else if ((in_oh[2:0] & slot_free) != 3'b000) begin
                        wr = in_oh[2:0];
                    end else begin
                        pend_data_nxt = in_data;
                        pend_sel_nxt  = in_sel;
                        state_nxt     = STALL;
                    end
                end
            end
            STALL: begin
                // Pending word replaces the departing one, so valid stays high.
                if ((pend_oh[2:0] & xfer) != 3'b000) begin
                    wr        = pend_oh[2:0];
                    wr_data   = pend_data;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pend_data <= '0;
            pend_sel  <= 2'b00;
            out0_data <= '0;
            out1_data <= '0;
            out2_data <= '0;
            out_valid <= 3'b000;
            drop_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            pend_data <= pend_data_nxt;
            pend_sel  <= pend_sel_nxt;
            if (wr[0]) out0_data <= wr_data;
            if (wr[1]) out1_data <= wr_data;
            if (wr[2]) out2_data <= wr_data;
            for (int k = 0; k < 3; k++) begin
                if (wr[k]) begin
                    out_valid[k] <= 1'b1;
                end else if (xfer[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
            if (drop && (drop_cnt != {CNT_BITS{1'b1}})) begin
                drop_cnt <= drop_cnt + {{(CNT_BITS-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_demux_1x4_reg.sv
// tb/tb_demux_1x4_reg.sv - self-checking bench for demux_1x4_reg
module tb_demux_1x4_reg;

    localparam int BITS     = 12;
    localparam int CNT_BITS = 2;
    localparam int CNT_MAX  = (1 << CNT_BITS) - 1;

    logic                clk;
    logic                rst;
    logic [BITS-1:0]     in_data;
    logic [1:0]          in_sel;
    logic                in_valid;
    logic                in_ready;
    logic [BITS-1:0]     out0_data;
    logic [BITS-1:0]     out1_data;
    logic [BITS-1:0]     out2_data;
    logic [2:0]          out_valid;
    logic [2:0]          out_ready;
    logic [CNT_BITS-1:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: per-channel slot, a queue holding at most one stalled word, a drop tally.
    bit              m_v[3];
    logic [BITS-1:0] m_d[3];
    logic [BITS-1:0] pq_d[$];
    int              pq_s[$];
    int              m_drops;

    demux_1x4_reg #(.BITS(BITS), .CNT_BITS(CNT_BITS)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
        .in_ready(in_ready), .out0_data(out0_data), .out1_data(out1_data),
        .out2_data(out2_data), .out_valid(out_valid), .out_ready(out_ready), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit took[3];
        int s;
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                m_v[k] = 0;
                m_d[k] = '0;
            end
            pq_d.delete();
            pq_s.delete();
            m_drops = 0;
            return;
        end
        for (int k = 0; k < 3; k++) begin
            took[k] = m_v[k] && out_ready[k];
            if (took[k]) m_v[k] = 0;
        end
        if (pq_s.size() != 0) begin
            s = pq_s[0];
            if (took[s]) begin
                m_v[s] = 1;
                m_d[s] = pq_d[0];
                void'(pq_s.pop_front());
                void'(pq_d.pop_front());
            end
        end else if (in_valid) begin
            s = int'(in_sel);
            if (s == 3) begin
                m_drops = (m_drops + 1 > CNT_MAX) ? CNT_MAX : m_drops + 1;
            end else if (!m_v[s]) begin
                m_v[s] = 1;
                m_d[s] = in_data;
            end else begin
                pq_s.push_back(s);
                pq_d.push_back(in_data);
            end
        end
    endtask

    // Inputs are already driven; check in_ready, advance model and DUT one edge, check outputs.
    task automatic cycle();
        logic [2:0] ev;
        #1;
        chk("in_ready", {31'b0, in_ready}, {31'b0, (!rst && pq_s.size() == 0)});
        model_edge();
        @(posedge clk);
        #1;
        ev = {m_v[2], m_v[1], m_v[0]};
        chk("out_valid", {29'b0, out_valid}, {29'b0, ev});
        chk("out0_data", {20'b0, out0_data}, {20'b0, m_d[0]});
        chk("out1_data", {20'b0, out1_data}, {20'b0, m_d[1]});
        chk("out2_data", {20'b0, out2_data}, {20'b0, m_d[2]});
        chk("drop_cnt", {30'b0, drop_cnt}, m_drops);
    endtask

    task automatic send(input logic [1:0] sel, input logic [BITS-1:0] d);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        cycle();
    endtask

    initial begin
        int exp_drop[5];
        exp_drop = '{1, 2, 3, 3, 3};
        rst = 1'b1; in_valid = 1'b0; in_sel = 2'b00; in_data = '0; out_ready = 3'b111;

        // Reset held for two cycles
        cycle();
        cycle();
        chk("rst_out_valid", {29'b0, out_valid}, 0);
        chk("rst_in_ready", {31'b0, in_ready}, 0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", {31'b0, in_ready}, 1);

        // Basic route to ch1
        send(2'b01, 12'hA5C);
        chk("route_data", {20'b0, out1_data}, 32'hA5C);
        chk("route_valid", {29'b0, out_valid}, 32'b010);
        in_valid = 1'b0;
        cycle();
        chk("route_drain", {29'b0, out_valid}, 0);

        // Stall on ch0
        out_ready = 3'b110;
        send(2'b00, 12'h111);
        send(2'b00, 12'h222);
        in_valid = 1'b0;
        cycle();
        chk("stall_hold", {20'b0, out0_data}, 32'h111);
        chk("stall_ready", {31'b0, in_ready}, 0);
        out_ready = 3'b111;
        cycle();
        chk("stall_release", {20'b0, out0_data}, 32'h222);
        chk("stall_ready_back", {31'b0, in_ready}, 1);
        cycle();

        // Back-to-back streaming to ch2
        send(2'b10, 12'h001);
        chk("stream0", {20'b0, out2_data}, 32'h001);
        send(2'b10, 12'h002);
        chk("stream1", {20'b0, out2_data}, 32'h002);
        send(2'b10, 12'h003);
        chk("stream2", {20'b0, out2_data}, 32'h003);
        chk("stream_valid", {31'b0, out_valid[2]}, 1);
        in_valid = 1'b0;
        cycle();

        // Null code saturates the drop counter
        for (int i = 0; i < 5; i++) begin
            send(2'b11, BITS'(i + 12'h300));
            chk("drop_seq", {30'b0, drop_cnt}, exp_drop[i]);
            chk("drop_valid", {29'b0, out_valid}, 0);
        end
        in_valid = 1'b0;
        cycle();

        // Reset while a word is pending
        out_ready = 3'b110;
        send(2'b00, 12'h444);
        send(2'b00, 12'h555);
        in_valid = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        out_ready = 3'b111;
        cycle();
        chk("rstmid_valid", {29'b0, out_valid}, 0);
        cycle();
        chk("rstmid_valid2", {29'b0, out_valid}, 0);
        chk("rstmid_ready", {31'b0, in_ready}, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 79) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = 2'($urandom_range(0, 3));
            in_data   = BITS'($urandom);
            out_ready = 3'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
